// File: rtl/sram_slave_mem.sv
// Word-organised synchronous memory behind the core's sram master port.
// Inserts LATENCY wait states per in-window access and flags out-of-window requests.
module sram_slave_mem #(
  parameter int          AW        = 12,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          LATENCY   = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] data_w,
  output logic [31:0] data_r,
  output logic        stall,
  output logic        err_r,
  output logic        err_w
);

  // Handshake: the master holds en/addr while stall=1; a request is taken in the
  // cycle where en=1 and stall=0, and read data appears in data_r one edge later.

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  logic [31:0]   mem [2**AW];
  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [31:0]   lat_addr, lat_addr_n;
  logic          hit;
  logic          accept;
  logic [AW-1:0] idx;

  assign hit   = (addr[31:AW+2] == BASE[31:AW+2]);
  assign idx   = addr[AW+1:2];
  assign err_r = en && !hit && (we == 4'h0);
  assign err_w = en && !hit && (we != 4'h0);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_addr_n = lat_addr;
    stall      = 1'b0;
    accept     = 1'b0;
    if (!rst) begin
      if (en && !hit) begin
        // Bus errors complete immediately and drop any pending wait sequence.
        state_n = IDLE;
        cnt_n   = 4'd0;
      end else if (LATENCY == 0) begin
        accept = en;
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              stall      = 1'b1;
              state_n    = WAIT;
              cnt_n      = 4'd1;
              lat_addr_n = addr;
            end
          end
          WAIT: begin
            if (!en) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
            end else if (addr != lat_addr) begin
              stall      = 1'b1;
              cnt_n      = 4'd1;
              lat_addr_n = addr;
            end else if (cnt < LAT4) begin
              stall = 1'b1;
              cnt_n = cnt + 4'd1;
            end else begin
              accept  = 1'b1;
              state_n = IDLE;
              cnt_n   = 4'd0;
            end
          end
          default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_addr <= 32'd0;
      data_r   <= 32'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat_addr <= lat_addr_n;
      if (en && !hit) begin
        data_r <= 32'd0;
      end else if (accept && (we == 4'h0)) begin
        data_r <= mem[idx];
      end
    end
  end

  // Array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[idx][8*i +: 8] <= data_w[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_slave_mem.sv
// Directed bench for sram_slave_mem: three instances at LATENCY 0, 3 and 5.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_sram_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        en     [3];
  logic [3:0]  we     [3];
  logic [31:0] addr   [3];
  logic [31:0] data_w [3];
  logic [31:0] data_r [3];
  logic        stall  [3];
  logic        err_r  [3];
  logic        err_w  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_slave_mem #(.AW(12), .BASE(32'h0), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .en(en[0]), .we(we[0]), .addr(addr[0]), .data_w(data_w[0]),
    .data_r(data_r[0]), .stall(stall[0]), .err_r(err_r[0]), .err_w(err_w[0])
  );

  sram_slave_mem #(.AW(12), .BASE(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .en(en[1]), .we(we[1]), .addr(addr[1]), .data_w(data_w[1]),
    .data_r(data_r[1]), .stall(stall[1]), .err_r(err_r[1]), .err_w(err_w[1])
  );

  sram_slave_mem #(.AW(12), .BASE(32'h0), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .en(en[2]), .we(we[2]), .addr(addr[2]), .data_w(data_w[2]),
    .data_r(data_r[2]), .stall(stall[2]), .err_r(err_r[2]), .err_w(err_w[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    en[k]     = e;
    we[k]     = w;
    addr[k]   = a;
    data_w[k] = d;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Holds a request for stalls+1 cycles, expecting stall=1 on all but the last.
  task automatic access(input int k, input string tag, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d, input int stalls);
    drive(k, 1'b1, w, a, d);
    for (int i = 0; i <= stalls; i++) begin
      @(negedge clk);
      check($sformatf("%s_stall%0d", tag, i), 32'(stall[k]), 32'(i < stalls));
      tick();
    end
  endtask

  // Holds a request for n cycles that must all stall, without completing it.
  task automatic partial(input int k, input string tag, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d, input int n);
    drive(k, 1'b1, w, a, d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_stall%0d", tag, i), 32'(stall[k]), 32'd1);
      tick();
    end
  endtask

  task automatic sample(input int k, input string tag, input logic [31:0] exp);
    @(negedge clk);
    check(tag, data_r[k], exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) idle(k);
    tick();
    @(negedge clk);
    check("rst_stall_l3", 32'(stall[1]), 32'd0);
    tick();
    @(negedge clk);
    check("rst_data_l0", data_r[0], 32'h0);
    check("rst_data_l5", data_r[2], 32'h0);
    rst = 1'b0;
    tick();

    // Zero-latency write then immediate read of the same word
    access(0, "t1_wr", 4'hF, 32'h10, 32'hDEADBEEF, 0);
    access(0, "t1_rd", 4'h0, 32'h10, 32'h0, 0);
    idle(0);
    sample(0, "t1_rd_data", 32'hDEADBEEF);

    // Byte strobes; a write leaves data_r alone
    access(0, "t2_wr", 4'hF, 32'h20, 32'h11223344, 0);
    idle(0);
    sample(0, "t2_hold", 32'hDEADBEEF);
    access(0, "t2_wb", 4'b0010, 32'h20, 32'h0000AB00, 0);
    access(0, "t2_rd", 4'h0, 32'h20, 32'h0, 0);
    idle(0);
    sample(0, "t2_rd_data", 32'h1122AB44);

    // Out-of-window read and write
    drive(0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
    @(negedge clk);
    check("t5_err_r", 32'(err_r[0]), 32'd1);
    check("t5_err_w_rd", 32'(err_w[0]), 32'd0);
    check("t5_stall_rd", 32'(stall[0]), 32'd0);
    tick();
    idle(0);
    @(negedge clk);
    check("t5_data_zero", data_r[0], 32'h0);
    check("t5_err_r_idle", 32'(err_r[0]), 32'd0);
    tick();
    drive(0, 1'b1, 4'hF, 32'h0001_0010, 32'h0BAD0BAD);
    @(negedge clk);
    check("t5_err_w", 32'(err_w[0]), 32'd1);
    check("t5_err_r_wr", 32'(err_r[0]), 32'd0);
    check("t5_stall_wr", 32'(stall[0]), 32'd0);
    tick();
    access(0, "t5_rd", 4'h0, 32'h10, 32'h0, 0);
    idle(0);
    sample(0, "t5_no_alias", 32'hDEADBEEF);

    // LATENCY=3: waits, back-to-back accesses
    access(1, "t3_wr40", 4'hF, 32'h40, 32'hCAFE0040, 3);
    access(1, "t3_wr44", 4'hF, 32'h44, 32'hCAFE0044, 3);
    access(1, "t3_rd40", 4'h0, 32'h40, 32'h0, 3);
    idle(1);
    sample(1, "t3_rd40_data", 32'hCAFE0040);
    access(1, "t3_b2b_a", 4'h0, 32'h40, 32'h0, 3);
    access(1, "t3_b2b_b", 4'h0, 32'h44, 32'h0, 3);
    idle(1);
    sample(1, "t3_b2b_data", 32'hCAFE0044);

    // Out-of-window with LATENCY>0 must not stall
    drive(1, 1'b1, 4'h0, 32'h2000_0000, 32'h0);
    @(negedge clk);
    check("t5_l3_stall", 32'(stall[1]), 32'd0);
    check("t5_l3_err_r", 32'(err_r[1]), 32'd1);
    tick();
    idle(1);
    sample(1, "t5_l3_data", 32'h0);

    // Flush after two stall cycles
    access(1, "t4_pre", 4'h0, 32'h40, 32'h0, 3);
    partial(1, "t4_rd", 4'h0, 32'h44, 32'h0, 2);
    idle(1);
    @(negedge clk);
    check("t4_flush_stall", 32'(stall[1]), 32'd0);
    tick();
    @(negedge clk);
    check("t4_state_idle", 32'(u_l3.state), 32'd0);
    check("t4_data_held", data_r[1], 32'hCAFE0040);
    tick();
    partial(1, "t4_wr", 4'hF, 32'h44, 32'h00000BAD, 2);
    idle(1);
    tick();
    access(1, "t4_rd44", 4'h0, 32'h44, 32'h0, 3);
    idle(1);
    sample(1, "t4_wr_aborted", 32'hCAFE0044);

    // Address change mid-wait restarts the count
    partial(1, "t4_chg", 4'h0, 32'h40, 32'h0, 2);
    access(1, "t4_new", 4'h0, 32'h44, 32'h0, 3);
    idle(1);
    sample(1, "t4_new_data", 32'hCAFE0044);

    // LATENCY=5: reset mid-wait aborts a write, memory survives
    access(2, "t6_wr", 4'hF, 32'h80, 32'h5A5AA5A5, 5);
    access(2, "t6_rd", 4'h0, 32'h80, 32'h0, 5);
    idle(2);
    sample(2, "t6_rd_data", 32'h5A5AA5A5);
    partial(2, "t6_abort", 4'hF, 32'h80, 32'h12345678, 2);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_stall", 32'(stall[2]), 32'd0);
    tick();
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    check("t6_post_stall", 32'(stall[2]), 32'd0);
    check("t6_post_data", data_r[2], 32'h0);
    check("t6_post_cnt", 32'(u_l5.cnt), 32'd0);
    check("t6_post_state", 32'(u_l5.state), 32'd0);
    tick();
    access(2, "t6_rd2", 4'h0, 32'h80, 32'h0, 5);
    idle(2);
    sample(2, "t6_mem_kept", 32'h5A5AA5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
